// File: rtl/exu_alu_ctrl_if.sv
// Issue, calculator and writeback signals of the ALU control block.
// The slave modport is the ALU control side; master is decode, writeback and calculator.
interface exu_alu_ctrl_if #(parameter int OPW = 4);
  logic           i_valid;
  logic           o_ready;
  logic [OPW-1:0] i_op;
  logic [31:0]    i_rs1;
  logic [31:0]    i_rs2;
  logic [31:0]    i_imm;
  logic           i_use_imm;
  logic [4:0]     i_rd;
  logic [64:0]    o_add_info;
  logic [63:0]    o_or_info;
  logic [63:0]    o_xor_info;
  logic [63:0]    o_and_info;
  logic [63:0]    o_slt_info;
  logic [63:0]    o_sltu_info;
  logic [36:0]    o_sll_info;
  logic [36:0]    o_srl_info;
  logic [36:0]    o_sra_info;
  logic [31:0]    i_result;
  logic [2:0]     i_cmp_res;
  logic           o_wb_valid;
  logic           i_wb_ready;
  logic [4:0]     o_wb_rd;
  logic [31:0]    o_wb_data;
  logic           o_br_valid;
  logic           o_br_taken;
  logic [31:0]    o_retire_cnt;

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_imm, i_use_imm, i_rd,
    input  i_result, i_cmp_res, i_wb_ready,
    output o_ready, o_add_info, o_or_info, o_xor_info, o_and_info,
    output o_slt_info, o_sltu_info, o_sll_info, o_srl_info, o_sra_info,
    output o_wb_valid, o_wb_rd, o_wb_data, o_br_valid, o_br_taken, o_retire_cnt
  );

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_imm, i_use_imm, i_rd,
    output i_result, i_cmp_res, i_wb_ready,
    input  o_ready, o_add_info, o_or_info, o_xor_info, o_and_info,
    input  o_slt_info, o_sltu_info, o_sll_info, o_srl_info, o_sra_info,
    input  o_wb_valid, o_wb_rd, o_wb_data, o_br_valid, o_br_taken, o_retire_cnt
  );
endinterface

// File: rtl/exu_alu_ctrl.sv
// One-deep ALU issue stage: holds an instruction, feeds the shared calculator through
// per-unit operand buses, and returns the result over a valid/ready writeback handshake.
module exu_alu_ctrl #(parameter int OPW = 4) (
  input logic           clk,
  input logic           rst_n,
  exu_alu_ctrl_if.slave alu
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(2);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(3);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_AND  = OPW'(9);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(10);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(11);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(12);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(13);
  localparam logic [OPW-1:0] OP_BLTU = OPW'(14);
  localparam logic [OPW-1:0] OP_BGEU = OPW'(15);

  logic           vld_q;
  logic [OPW-1:0] op_q;
  logic [31:0]    op1_q;
  logic [31:0]    op2_q;
  logic [4:0]     rd_q;
  logic [31:0]    retire_q;
  logic           accept;
  logic           retire;
  logic           is_br_in;
  logic           is_br_q;

  assign is_br_in    = (alu.i_op >= OP_BEQ);
  assign is_br_q     = (op_q >= OP_BEQ);
  assign alu.o_ready = ~vld_q | alu.i_wb_ready;
  assign accept      = alu.i_valid & alu.o_ready;
  assign retire      = vld_q & alu.i_wb_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      retire_q <= '0;
    end else begin
      if (accept) begin
        vld_q <= 1'b1;
        op_q  <= alu.i_op;
        op1_q <= alu.i_rs1;
        // branches always compare against rs2
        op2_q <= (alu.i_use_imm & ~is_br_in) ? alu.i_imm : alu.i_rs2;
        rd_q  <= alu.i_rd;
      end else if (retire) begin
        vld_q <= 1'b0;
      end
      if (retire) retire_q <= retire_q + 32'd1;
    end
  end

  // Idle buses must be zero: the calculator ORs all unit results together.
  always_comb begin
    alu.o_add_info  = '0;
    alu.o_or_info   = '0;
    alu.o_xor_info  = '0;
    alu.o_and_info  = '0;
    alu.o_slt_info  = '0;
    alu.o_sltu_info = '0;
    alu.o_sll_info  = '0;
    alu.o_srl_info  = '0;
    alu.o_sra_info  = '0;
    if (vld_q) begin
      case (op_q)
        OP_ADD:                  alu.o_add_info  = {1'b0, op2_q, op1_q};
        OP_SUB:                  alu.o_add_info  = {1'b1, ~op2_q, op1_q};
        OP_SLL:                  alu.o_sll_info  = {op2_q[4:0], op1_q};
        OP_SRL:                  alu.o_srl_info  = {op2_q[4:0], op1_q};
        OP_SRA:                  alu.o_sra_info  = {op2_q[4:0], op1_q};
        OP_XOR:                  alu.o_xor_info  = {op2_q, op1_q};
        OP_OR:                   alu.o_or_info   = {op2_q, op1_q};
        OP_AND:                  alu.o_and_info  = {op2_q, op1_q};
        OP_SLT, OP_BLT, OP_BGE:  alu.o_slt_info  = {op2_q, op1_q};
        OP_SLTU, OP_BEQ, OP_BNE,
        OP_BLTU, OP_BGEU:        alu.o_sltu_info = {op2_q, op1_q};
        default: ;
      endcase
    end
  end

  always_comb begin
    alu.o_wb_data  = alu.i_result;
    alu.o_br_taken = 1'b0;
    case (op_q)
      OP_SLT:  alu.o_wb_data = {31'b0, ~alu.i_cmp_res[2]};
      OP_SLTU: alu.o_wb_data = {31'b0, ~alu.i_cmp_res[1]};
      default: if (is_br_q) alu.o_wb_data = '0;
    endcase
    if (vld_q) begin
      case (op_q)
        OP_BEQ:  alu.o_br_taken =  alu.i_cmp_res[0];
        OP_BNE:  alu.o_br_taken = ~alu.i_cmp_res[0];
        OP_BLT:  alu.o_br_taken = ~alu.i_cmp_res[2];
        OP_BGE:  alu.o_br_taken =  alu.i_cmp_res[2];
        OP_BLTU: alu.o_br_taken = ~alu.i_cmp_res[1];
        OP_BGEU: alu.o_br_taken =  alu.i_cmp_res[1];
        default: ;
      endcase
    end
  end

  assign alu.o_wb_valid   = vld_q;
  assign alu.o_wb_rd      = is_br_q ? 5'd0 : rd_q;
  assign alu.o_br_valid   = vld_q & is_br_q;
  assign alu.o_retire_cnt = retire_q;

endmodule

// File: tb/tb_exu_alu_ctrl.sv
// Bench for exu_alu_ctrl: a behavioural calculator answers the info buses, and
// results are checked against an opcode-level reference model.
module tb_exu_alu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exu_alu_ctrl_if #(.OPW(4)) bus ();
  exu_alu_ctrl #(.OPW(4)) dut (.clk(clk), .rst_n(rst_n), .alu(bus));

  // calculator: each unit computes from its bus, results ORed
  logic [31:0] c_sum, c_sra, c_a, c_b;
  assign c_sum = bus.o_add_info[31:0] + bus.o_add_info[63:32] + {31'b0, bus.o_add_info[64]};
  assign c_sra = $signed(bus.o_sra_info[31:0]) >>> bus.o_sra_info[36:32];
  assign c_a   = bus.o_slt_info[31:0]  | bus.o_sltu_info[31:0];
  assign c_b   = bus.o_slt_info[63:32] | bus.o_sltu_info[63:32];
  assign bus.i_result = c_sum | c_sra
                      | (bus.o_sll_info[31:0] << bus.o_sll_info[36:32])
                      | (bus.o_srl_info[31:0] >> bus.o_srl_info[36:32])
                      | (bus.o_xor_info[31:0] ^ bus.o_xor_info[63:32])
                      | (bus.o_or_info[31:0]  | bus.o_or_info[63:32])
                      | (bus.o_and_info[31:0] & bus.o_and_info[63:32]);
  assign bus.i_cmp_res = {$signed(c_a) >= $signed(c_b), c_a >= c_b, c_a == c_b};

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        brv;
    logic        taken;
  } exp_t;

  function automatic logic [31:0] ref_data(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return $signed(a) >>> b[4:0];
      8: return a | b;
      9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      10: return a == b;
      11: return a != b;
      12: return $signed(a) < $signed(b);
      13: return $signed(a) >= $signed(b);
      14: return a < b;
      15: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t ref_model(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    b = (use_imm && op < 10) ? imm : rs2;
    e.data  = ref_data(op, rs1, b);
    e.rd    = (op >= 10) ? 5'd0 : rd;
    e.brv   = (op >= 10);
    e.taken = ref_taken(op, rs1, b);
    return e;
  endfunction

  task automatic drive(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] rd, input logic v);
    bus.i_op = 4'(op); bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm;
    bus.i_use_imm = use_imm; bus.i_rd = rd; bus.i_valid = v;
  endtask

  // drive one issue; returns just after the capture edge with outputs settled
  task automatic issue_one(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
    @(negedge clk);
    drive(op, rs1, rs2, imm, use_imm, rd, 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_wb_ready = 1'b0;
    drive(0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd3, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.o_wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", bus.o_wb_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.o_br_valid !== 1'b0) begin failures++; $display("FAIL reset_br_valid got=%b exp=0", bus.o_br_valid); end
    checks++; if (bus.o_retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_retire got=%h exp=0", bus.o_retire_cnt); end
    checks++;
    if ((bus.o_add_info | {1'b0, bus.o_or_info | bus.o_xor_info | bus.o_and_info | bus.o_slt_info | bus.o_sltu_info}
         | {28'b0, bus.o_sll_info | bus.o_srl_info | bus.o_sra_info}) !== 65'd0) begin
      failures++; $display("FAIL reset_info_zero got=%h exp=0", bus.o_add_info);
    end
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    bus.i_wb_ready = 1'b1;
  endtask

  task automatic test_sub();
    issue_one(1, 32'd5, 32'd7, 32'hDEAD_BEEF, 1'b0, 5'd9);
    checks++; if (bus.o_add_info !== {1'b1, 32'hFFFF_FFF8, 32'd5}) begin failures++; $display("FAIL sub_add_info got=%h exp=%h", bus.o_add_info, {1'b1, 32'hFFFF_FFF8, 32'd5}); end
    checks++; if (bus.o_wb_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_wb_data got=%h exp=fffffffe", bus.o_wb_data); end
    checks++; if (bus.o_wb_rd !== 5'd9) begin failures++; $display("FAIL sub_wb_rd got=%0d exp=9", bus.o_wb_rd); end
    checks++;
    if ((bus.o_or_info | bus.o_xor_info | bus.o_and_info | bus.o_slt_info | bus.o_sltu_info) !== 64'd0 ||
        (bus.o_sll_info | bus.o_srl_info | bus.o_sra_info) !== 37'd0) begin
      failures++; $display("FAIL sub_other_buses got=%h exp=0", bus.o_slt_info | bus.o_sltu_info);
    end
  endtask

  task automatic test_slt();
    issue_one(3, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd4);
    checks++; if (bus.o_wb_data !== 32'd1) begin failures++; $display("FAIL slt_data got=%h exp=1", bus.o_wb_data); end
    issue_one(4, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd4);
    checks++; if (bus.o_wb_data !== 32'd0) begin failures++; $display("FAIL sltu_data got=%h exp=0", bus.o_wb_data); end
  endtask

  task automatic test_branch();
    issue_one(15, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 5'd7);
    checks++; if (bus.o_br_valid !== 1'b1) begin failures++; $display("FAIL bgeu_br_valid got=%b exp=1", bus.o_br_valid); end
    checks++; if (bus.o_br_taken !== 1'b1) begin failures++; $display("FAIL bgeu_taken got=%b exp=1", bus.o_br_taken); end
    checks++; if (bus.o_wb_rd !== 5'd0) begin failures++; $display("FAIL bgeu_rd got=%0d exp=0", bus.o_wb_rd); end
    checks++; if (bus.o_wb_data !== 32'd0) begin failures++; $display("FAIL bgeu_data got=%h exp=0", bus.o_wb_data); end
    issue_one(11, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 5'd7);
    checks++; if (bus.o_br_taken !== 1'b0) begin failures++; $display("FAIL bne_taken got=%b exp=0", bus.o_br_taken); end
  endtask

  task automatic test_sra();
    issue_one(7, 32'h8000_0000, 32'h24, 32'd0, 1'b0, 5'd2);
    checks++; if (bus.o_sra_info !== {5'd4, 32'h8000_0000}) begin failures++; $display("FAIL sra_info got=%h exp=%h", bus.o_sra_info, {5'd4, 32'h8000_0000}); end
    checks++; if (bus.o_wb_data !== 32'hF800_0000) begin failures++; $display("FAIL sra_data got=%h exp=f8000000", bus.o_wb_data); end
  endtask

  task automatic test_backpressure();
    exp_t exp_q[3];
    int ops[3] = '{0, 5, 8};
    int idx = 0;
    int done = 0;
    logic exp_valid, exp_ready;
    do_reset();
    for (int k = 0; k < 3; k++) exp_q[k] = ref_model(ops[k], 32'h10 + 32'(k), 32'h0F0F_0003, 32'd0, 1'b0, 5'(k + 1));
    for (int cyc = 0; cyc < 40 && done < 3; cyc++) begin
      @(negedge clk);
      if (idx < 3) drive(ops[idx], 32'h10 + 32'(idx), 32'h0F0F_0003, 32'd0, 1'b0, 5'(idx + 1), 1'b1);
      else bus.i_valid = 1'b0;
      bus.i_wb_ready = (cyc >= 5);
      #1;
      exp_valid = (idx > done);
      exp_ready = !exp_valid || bus.i_wb_ready;
      checks++; if (bus.o_wb_valid !== exp_valid) begin failures++; $display("FAIL bp_wb_valid cyc=%0d got=%b exp=%b", cyc, bus.o_wb_valid, exp_valid); end
      checks++; if (bus.o_ready !== exp_ready) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, bus.o_ready, exp_ready); end
      if (exp_valid) begin
        checks++;
        if (bus.o_wb_data !== exp_q[done].data || bus.o_wb_rd !== exp_q[done].rd) begin
          failures++; $display("FAIL bp_data cyc=%0d got=%h/%0d exp=%h/%0d", cyc, bus.o_wb_data, bus.o_wb_rd, exp_q[done].data, exp_q[done].rd);
        end
      end
      if (exp_valid && bus.i_wb_ready) done++;
      if (idx < 3 && exp_ready) idx++;
    end
    bus.i_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (done != 3) begin failures++; $display("FAIL bp_timeout got=%0d exp=3", done); end
    checks++; if (bus.o_retire_cnt !== 32'd3) begin failures++; $display("FAIL bp_retire got=%0d exp=3", bus.o_retire_cnt); end
  endtask

  task automatic test_wrap_and_midreset();
    do_reset();
    bus.i_wb_ready = 1'b1;
    @(negedge clk);
    dut.retire_q = 32'hFFFF_FFFF;
    issue_one(9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 5'd1);
    checks++; if (bus.o_retire_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffffffff", bus.o_retire_cnt); end
    @(negedge clk); #1;
    checks++; if (bus.o_retire_cnt !== 32'd0) begin failures++; $display("FAIL wrap_post got=%h exp=0", bus.o_retire_cnt); end
    dut.retire_q = 32'hFFFF_FFFF;
    bus.i_wb_ready = 1'b0;
    issue_one(0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1);
    checks++; if (bus.o_wb_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.o_wb_valid); end
    rst_n = 1'b0;
    drive(0, 32'd2, 32'd2, 32'd0, 1'b0, 5'd2, 1'b1);
    @(negedge clk); #1;
    checks++; if (bus.o_wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.o_wb_valid); end
    checks++; if (bus.o_retire_cnt !== 32'd0) begin failures++; $display("FAIL midrst_retire got=%h exp=0", bus.o_retire_cnt); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.o_ready); end
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    bus.i_wb_ready = 1'b1;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [31:0] cnt = 32'd0;
    logic exp_ready;
    int op;
    logic [31:0] rs1, rs2, imm;
    logic use_imm;
    logic [4:0] rd;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      op = $urandom_range(0, 15);
      rs1 = $urandom; rs2 = $urandom; imm = $urandom;
      if ($urandom_range(0, 7) == 0) rs2 = rs1;
      use_imm = 1'($urandom);
      rd = 5'($urandom);
      drive(op, rs1, rs2, imm, use_imm, rd, ($urandom_range(0, 3) != 0));
      bus.i_wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || bus.i_wb_ready;
      checks++; if (bus.o_wb_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", cyc, bus.o_wb_valid, q.size() != 0); end
      checks++; if (bus.o_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.o_ready, exp_ready); end
      checks++; if (bus.o_retire_cnt !== cnt) begin failures++; $display("FAIL rnd_retire cyc=%0d got=%0d exp=%0d", cyc, bus.o_retire_cnt, cnt); end
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (bus.o_wb_data !== e.data || bus.o_wb_rd !== e.rd || bus.o_br_valid !== e.brv || bus.o_br_taken !== e.taken) begin
          failures++;
          $display("FAIL rnd_result cyc=%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", cyc,
                   bus.o_wb_data, bus.o_wb_rd, bus.o_br_valid, bus.o_br_taken, e.data, e.rd, e.brv, e.taken);
        end
        if (bus.i_wb_ready) begin
          void'(q.pop_front());
          cnt = cnt + 32'd1;
        end
      end
      if (bus.i_valid && exp_ready) q.push_back(ref_model(op, rs1, rs2, imm, use_imm, rd));
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_wb_ready = 1'b1;
    drive(0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_sub();
    test_slt();
    test_branch();
    test_sra();
    test_backpressure();
    test_wrap_and_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
